// File: rtl/bram_reader_pkg.sv
// Shared constants and sizing helpers for the bram_sync_sp read engine.
// The output buffer holds READ_LATENCY+1 words.
package bram_reader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    // One slot per pipeline stage plus one, which keeps the stream at full rate.
    function automatic int buf_depth(input int read_latency);
        return read_latency + 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/bram_reader_out_fifo.sv
// Small first-word-fall-through FIFO that holds {last, data} entries.
// pop_data always shows the head entry, so it is stable while the entry waits.
module bram_reader_out_fifo
    import bram_reader_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2,
    parameter int CNT_W = ptr_width(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = CNT_W - 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? {PTR_W{1'b0}} : (p + PTR_ONE);
    endfunction

    assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
    assign push_ok_s = push && ((count_r < DEPTH_C) || pop_ok_s);

    // Storage array; cleared on reset so the stream data reads as zero afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Read/write pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= push_ok_s ? next_ptr(wr_ptr_r) : wr_ptr_r;
            rd_ptr_r <= pop_ok_s  ? next_ptr(rd_ptr_r) : rd_ptr_r;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign count    = count_r;

endmodule

// File: rtl/bram_sync_sp_reader.sv
// Read engine for the single-port synchronous BRAM. It walks an address range,
// tracks the fixed read latency, and streams the words out with a credit-limited buffer.
module bram_sync_sp_reader
    import bram_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_wr,
    output logic                  bram_rd_en,
    input  logic [DATA_WIDTH-1:0] bram_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int DEPTH = buf_depth(READ_LATENCY);
    localparam int CNT_W = ptr_width(DEPTH) + 1;
    localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ZERO = (ADDR_WIDTH + 1)'(0);

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [ADDR_WIDTH:0]     rem_issue_r;
    logic [ADDR_WIDTH:0]     rem_out_r;
    logic [CNT_W-1:0]        used_r;
    logic [READ_LATENCY-1:0] vld_pipe_r;
    logic [READ_LATENCY-1:0] last_pipe_r;
    logic                    done_zero_r;

    logic                    accept_s;
    logic                    zero_start_s;
    logic                    issue_s;
    logic                    pop_s;
    logic                    final_pop_s;
    logic                    push_s;
    logic [DATA_WIDTH:0]     fifo_out_s;
    logic [CNT_W-1:0]        fifo_count_s;

    assign accept_s     = (state_r == ST_IDLE) && start && (length != LEN_ZERO);
    assign zero_start_s = (state_r == ST_IDLE) && start && (length == LEN_ZERO);
    assign m_valid      = (fifo_count_s != {CNT_W{1'b0}});
    assign pop_s        = m_valid && m_ready;
    // A pop in this cycle frees its slot in time for a read issued in the same cycle.
    assign issue_s      = (state_r == ST_ISSUE) && ((used_r < DEPTH_C) || pop_s);
    assign final_pop_s  = (state_r == ST_DRAIN) && pop_s && (rem_out_r == LEN_ONE);
    assign push_s       = vld_pipe_r[READ_LATENCY-1];

    // Control FSM together with the issue address and issue counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            rem_issue_r <= LEN_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r     <= ST_ISSUE;
                        addr_r      <= start_addr;
                        rem_issue_r <= length;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_s) begin
                        addr_r      <= addr_r + ADDR_ONE;
                        rem_issue_r <= rem_issue_r - LEN_ONE;
                        state_r     <= (rem_issue_r == LEN_ONE) ? ST_DRAIN : ST_ISSUE;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_DRAIN: begin
                    state_r <= final_pop_s ? ST_IDLE : ST_DRAIN;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Words still owed downstream, and the zero-length completion strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_out_r   <= LEN_ZERO;
            done_zero_r <= 1'b0;
        end else begin
            done_zero_r <= zero_start_s;
            if (accept_s) begin
                rem_out_r <= length;
            end else if (pop_s) begin
                rem_out_r <= rem_out_r - LEN_ONE;
            end else begin
                rem_out_r <= rem_out_r;
            end
        end
    end

    // Credits in use: words buffered plus reads still inside the BRAM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_r <= {CNT_W{1'b0}};
        end else begin
            case ({issue_s, pop_s})
                2'b10:   used_r <= used_r + CNT_ONE;
                2'b01:   used_r <= used_r - CNT_ONE;
                default: used_r <= used_r;
            endcase
        end
    end

    // Read-valid and last-word tags delayed to line up with bram_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_r  <= {READ_LATENCY{1'b0}};
            last_pipe_r <= {READ_LATENCY{1'b0}};
        end else begin
            vld_pipe_r[0]  <= issue_s;
            last_pipe_r[0] <= issue_s && (rem_issue_r == LEN_ONE);
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe_r[i]  <= vld_pipe_r[i-1];
                last_pipe_r[i] <= last_pipe_r[i-1];
            end
        end
    end

    bram_reader_out_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data ({last_pipe_r[READ_LATENCY-1], bram_data}),
        .pop       (pop_s),
        .pop_data  (fifo_out_s),
        .count     (fifo_count_s)
    );

    assign busy       = (state_r != ST_IDLE);
    assign done       = done_zero_r || final_pop_s;
    assign bram_addr  = addr_r;
    assign bram_wr    = 1'b0;
    assign bram_rd_en = issue_s;
    assign m_data     = fifo_out_s[DATA_WIDTH-1:0];
    assign m_last     = fifo_out_s[DATA_WIDTH] && m_valid;

endmodule

// File: tb/tb_bram_sync_sp_reader.sv
// Directed bench: three reader instances (READ_LATENCY 1..3) on a shared clock,
// each with a behavioural BRAM preloaded with mem[k] = k*3.
module tb_bram_sync_sp_reader;

    logic        clk;
    logic        rst_n;
    logic        start_a [3];
    logic [3:0]  start_addr;
    logic [4:0]  length;
    logic        m_ready;

    logic        busy_a   [3];
    logic        done_a   [3];
    logic [3:0]  baddr_a  [3];
    logic        bwr_a    [3];
    logic        rd_en_a  [3];
    logic [31:0] bdata_a  [3];
    logic [31:0] m_data_a [3];
    logic        m_valid_a[3];
    logic        m_last_a [3];

    logic [31:0] mem [16];
    int          err_cnt;
    int          chk_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] p1, p2, p3;

        always @(posedge clk) begin
            p1 <= mem[baddr_a[g]];
            p2 <= p1;
            p3 <= p2;
        end

        assign bdata_a[g] = (g == 0) ? p1 : ((g == 1) ? p2 : p3);

        bram_sync_sp_reader #(
            .DATA_WIDTH   (32),
            .ADDR_WIDTH   (4),
            .READ_LATENCY (g + 1)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start_a[g]),
            .start_addr (start_addr),
            .length     (length),
            .busy       (busy_a[g]),
            .done       (done_a[g]),
            .bram_addr  (baddr_a[g]),
            .bram_wr    (bwr_a[g]),
            .bram_rd_en (rd_en_a[g]),
            .bram_data  (bdata_a[g]),
            .m_data     (m_data_a[g]),
            .m_valid    (m_valid_a[g]),
            .m_last     (m_last_a[g]),
            .m_ready    (m_ready)
        );
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One transfer on instance d; rmode 0 = ready always high, 1 = ready on every third cycle.
    // spur_c: cycle for an extra start pulse; abort_c: cycle after which the task returns early.
    task automatic run_xfer(input int d, input int saddr, input int len, input int rmode,
                            input int spur_c, input int abort_c);
        int          c, nacc, niss, first_c, last_c, ndone, max_out, rl;
        logic        prev_stall, fin;
        logic [31:0] prev_data;
        rl = d + 1;
        @(negedge clk);
        start_a[d] = 1'b1;
        start_addr = saddr[3:0];
        length     = len[4:0];
        m_ready    = 1'b0;
        @(negedge clk);
        start_a[d] = 1'b0;
        c = 0; nacc = 0; niss = 0; first_c = -1; last_c = -1; ndone = 0; max_out = 0;
        prev_stall = 1'b0; prev_data = 32'd0; fin = 1'b0;
        while (!fin && c < 300) begin
            m_ready = (rmode == 0) ? 1'b1 : (c % 3 == 0);
            if (c == spur_c) begin
                start_a[d] = 1'b1;
                start_addr = 4'd5;
                length     = 5'd3;
            end else begin
                start_a[d] = 1'b0;
            end
            #1;
            if (c == 0) check_val("busy_after_start", 32'(busy_a[d]), 32'd1);
            if (niss - nacc > max_out) max_out = niss - nacc;
            if (rd_en_a[d]) begin
                check_val("rd_addr", 32'(baddr_a[d]), 32'((saddr + niss) % 16));
                niss++;
            end
            if (prev_stall) begin
                check_val("hold_data", m_data_a[d], prev_data);
                check_val("hold_valid", 32'(m_valid_a[d]), 32'd1);
            end
            if (m_valid_a[d] && first_c < 0) first_c = c;
            if (done_a[d]) ndone++;
            if (last_c >= 0 && c == last_c + 1) begin
                check_val("busy_after_done", 32'(busy_a[d]), 32'd0);
                fin = 1'b1;
            end
            if (m_valid_a[d] && m_ready) begin
                check_val("data", m_data_a[d], 32'(((saddr + nacc) % 16) * 3));
                check_val("last", 32'(m_last_a[d]), 32'(nacc == len - 1));
                if (nacc == len - 1) begin
                    check_val("done_with_last", 32'(done_a[d]), 32'd1);
                    last_c = c;
                end
                nacc++;
            end
            prev_stall = m_valid_a[d] && !m_ready;
            prev_data  = m_data_a[d];
            if (c == abort_c) return;
            c++;
            @(negedge clk);
        end
        check_val("finished_in_time", 32'(fin), 32'd1);
        check_val("first_latency", 32'(first_c), 32'(rl + 1));
        check_val("done_count", 32'(ndone), 32'd1);
        check_val("words_out", 32'(nacc), 32'(len));
        check_val("reads_issued", 32'(niss), 32'(len));
        check_val("credit_bound", 32'(max_out <= rl + 1), 32'd1);
        if (rmode == 0) check_val("throughput", 32'(last_c), 32'(first_c + len - 1));
    endtask

    initial begin
        int nre, ndn;
        err_cnt = 0;
        chk_cnt = 0;
        for (int k = 0; k < 16; k++) mem[k] = 32'(k * 3);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
        start_addr = 4'd0;
        length     = 5'd0;
        m_ready    = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check_val("rst_busy", 32'(busy_a[0]), 32'd0);
        check_val("rst_done", 32'(done_a[0]), 32'd0);
        check_val("rst_addr", 32'(baddr_a[0]), 32'd0);
        check_val("rst_rd_en", 32'(rd_en_a[0]), 32'd0);
        check_val("rst_valid", 32'(m_valid_a[0]), 32'd0);
        check_val("rst_last", 32'(m_last_a[0]), 32'd0);
        check_val("rst_data", m_data_a[0], 32'd0);
        check_val("bram_wr", 32'(bwr_a[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_xfer(0, 2, 5, 0, -1, -1);
        run_xfer(0, 14, 4, 0, -1, -1);
        run_xfer(0, 2, 6, 1, -1, -1);

        // Zero-length request
        @(negedge clk);
        start_a[0] = 1'b1;
        start_addr = 4'd3;
        length     = 5'd0;
        @(negedge clk);
        start_a[0] = 1'b0;
        #1;
        check_val("len0_done", 32'(done_a[0]), 32'd1);
        check_val("len0_busy", 32'(busy_a[0]), 32'd0);
        nre = rd_en_a[0] ? 1 : 0;
        ndn = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (done_a[0]) ndn++;
            if (rd_en_a[0]) nre++;
        end
        check_val("len0_no_reads", 32'(nre), 32'd0);
        check_val("len0_single_done", 32'(ndn), 32'd0);

        // Full-memory read with an ignored start in the middle
        run_xfer(0, 0, 16, 0, 5, -1);
        repeat (3) @(negedge clk);
        #1;
        check_val("spur_start_busy", 32'(busy_a[0]), 32'd0);
        check_val("spur_start_valid", 32'(m_valid_a[0]), 32'd0);

        // Reset during the third output cycle of a length-8 read
        run_xfer(0, 0, 8, 0, -1, 4);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", 32'(busy_a[0]), 32'd0);
        check_val("mid_rst_done", 32'(done_a[0]), 32'd0);
        check_val("mid_rst_addr", 32'(baddr_a[0]), 32'd0);
        check_val("mid_rst_rd_en", 32'(rd_en_a[0]), 32'd0);
        check_val("mid_rst_valid", 32'(m_valid_a[0]), 32'd0);
        check_val("mid_rst_last", 32'(m_last_a[0]), 32'd0);
        check_val("mid_rst_data", m_data_a[0], 32'd0);
        ndn = 0;
        repeat (2) begin
            @(negedge clk);
            #1;
            if (done_a[0]) ndn++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            if (done_a[0] || busy_a[0]) ndn++;
        end
        check_val("mid_rst_no_done", 32'(ndn), 32'd0);
        run_xfer(0, 2, 5, 0, -1, -1);

        // Deeper BRAM latencies
        run_xfer(1, 2, 5, 0, -1, -1);
        run_xfer(2, 2, 5, 0, -1, -1);
        run_xfer(2, 2, 6, 1, -1, -1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/bram_sync_sp_reader.md
Name: bram_sync_sp_reader

Overview:
Read-side engine for the bram_sync_sp single-port synchronous BRAM. On a start command it walks a contiguous address range and issues reads to the BRAM port. It tracks the BRAM's fixed read latency and presents the words as a valid/ready stream with a last flag. A small credit-limited output buffer absorbs downstream backpressure, so no read data is ever lost or duplicated.

Parameters:
DATA_WIDTH, 32, BRAM word width in bits.
ADDR_WIDTH, 10, BRAM address width in bits.
READ_LATENCY, 1, clock cycles from a driven address to a valid BRAM data_out; legal range 1-3.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle command strobe; sampled only in IDLE.
start_addr  in  ADDR_WIDTH  first address to read.
length  in  ADDR_WIDTH+1  number of words to read, 0 to 2^ADDR_WIDTH.
busy  out  1  high from the accepted start until the last word is accepted downstream.
done  out  1  one-cycle pulse when the final word is accepted, or immediately for length 0.
bram_addr  out  ADDR_WIDTH  address to the BRAM addr port.
bram_wr  out  1  constant 0; this block never writes.
bram_rd_en  out  1  high in every cycle a read is issued; used internally for latency tracking.
bram_data  in  DATA_WIDTH  BRAM data_out.
m_data  out  DATA_WIDTH  stream data.
m_valid  out  1  stream valid.
m_last  out  1  marks the final word of a transfer, qualified by m_valid.
m_ready  in  1  downstream ready.

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: busy=0, done=0, bram_addr=0, bram_rd_en=0, m_valid=0, m_last=0, m_data=0. FSM goes to IDLE and all counters, the pipeline and the buffer are cleared.
- Reset asserted mid-transfer: the transfer is abandoned and no done pulse is produced. After release the block sits in IDLE.
- FSM states:
  - IDLE -> ISSUE when start=1 and length!=0. The block latches addr=start_addr, remaining_issue=length, remaining_out=length.
  - IDLE with start=1 and length=0: done pulses on the next cycle, busy stays 0, no reads are issued.
  - ISSUE: in each cycle where credit is available, drive bram_addr=addr and bram_rd_en=1, then increment addr modulo 2^ADDR_WIDTH (wraps from 2^ADDR_WIDTH-1 to 0) and decrement remaining_issue. Move to DRAIN after the issue that takes remaining_issue to 0.
  - DRAIN -> IDLE in the cycle the word with m_last=1 is accepted (m_valid & m_ready). done pulses in that same cycle and busy drops on the following cycle.
- Start while busy is ignored.
- Read pipeline: bram_rd_en is delayed by a READ_LATENCY-deep valid shift register. When the delayed valid is 1, bram_data is pushed into the output buffer.
- Output buffer: FIFO of depth D = READ_LATENCY+1.
  - Credit rule: a read may issue only when (buffer occupancy + reads in flight) < D. The buffer therefore never overflows.
  - Full throughput: with m_ready held at 1, one word is emitted per cycle after an initial latency of READ_LATENCY+1 cycles from start.
- Stream rules:
  - m_data, m_valid and m_last are held stable while m_valid=1 and m_ready=0.
  - m_valid may assert independently of m_ready.
  - m_last=1 only on the word that takes remaining_out from 1 to 0.
- Simultaneous push and pop on a full buffer is legal; occupancy is unchanged.
- Width rules:
  - length is ADDR_WIDTH+1 bits so that a full-memory read of 2^ADDR_WIDTH words is expressible.
  - addr arithmetic is modulo 2^ADDR_WIDTH.
  - Values of length greater than 2^ADDR_WIDTH are illegal; behaviour for them is unspecified.

Decomposition:
- Package bram_reader_pkg holds:
  - FSM state encoding constants ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_DRAIN=2'd2.
  - The derived buffer-depth function D=READ_LATENCY+1 and its pointer width.
- One sub-module, bram_reader_out_fifo: a parameterised synchronous FIFO of width DATA_WIDTH+1 (data plus last flag). It has push/pop/count ports, asynchronous active-low reset and first-word-fall-through output.
- The FSM, the credit counter and the latency shift register stay in the top module.

Test Plan:
- Preload BRAM addr k with k*3 (DATA_WIDTH=32, ADDR_WIDTH=4, READ_LATENCY=1). Issue start, start_addr=2, length=5, m_ready=1 -> m_data 6,9,12,15,18 on consecutive cycles, first word 2 cycles after start. m_last is set on 18, done pulses with it, busy falls on the next cycle.
- Wrap-around: start_addr=14, length=4 -> addresses 14,15,0,1 are read. Output is 42,45,0,3 with m_last on 3.
- Backpressure: length=6 with m_ready toggling 1,0,0,1,... -> all 6 words appear in order with none dropped or duplicated. Data is held stable during stalls, and occupancy plus in-flight reads never exceed 2.
- Edge lengths: length=0 -> done one cycle later, bram_rd_en never asserts. length=16 from start_addr=0 -> all 16 words are read and m_last is set on word 15. A start pulse during that transfer is ignored.
- Reset mid-transfer: rst_n asserted in the 3rd output cycle of a length-8 read -> all outputs go to 0 immediately, there is no done pulse, and a new start after release reads correctly.
- Latency variants: repeat the first scenario with READ_LATENCY=2 and 3 -> identical data order, first word after READ_LATENCY+1 cycles, full throughput maintained with m_ready=1.
